// File: rtl/bip_result_tx.sv
// ============================================================================
//  Module   : bip_result_tx
//  Purpose  : On a rising edge of the CPU halt flag, captures the accumulator
//             and sends it LSB-byte first over an 8N1 UART TX line.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_result_tx #(
    parameter int NBITS_D      = 16,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_Halt,
    input  logic [NBITS_D-1:0] i_ACC,
    output logic               o_Tx,
    output logic               o_Busy,
    output logic               o_Done
);

    localparam int NBYTES = NBITS_D / 8;
    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               halt_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [BW-1:0]      byte_q, byte_d;
    logic [NBITS_D-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               trigger;
    logic               baud_end;
    logic [7:0]         cur_byte_d;

    assign trigger  = i_Halt & ~halt_q & (state_q == S_IDLE);
    assign baud_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (trigger) begin
                    shift_d = i_ACC;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (byte_q != BYTE_LAST) begin
                        // Next byte follows immediately, no idle gap
                        byte_d  = byte_q + BW'(1);
                        shift_d = shift_q >> 8;
                        state_d = S_START;
                    end else begin
                        byte_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they are registered
    assign cur_byte_d = shift_d[7:0];

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            halt_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= i_Halt;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_Tx   = tx_q;
    assign o_Busy = busy_q;
    assign o_Done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bip_result_tx.sv
// ============================================================================
//  Module   : tb_bip_result_tx
//  Purpose  : Self-checking bench for bip_result_tx (CLKS_PER_BIT=4, 16-bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bip_result_tx;

    localparam int NB  = 16;
    localparam int CPB = 4;
    localparam int NBY = NB / 8;
    localparam int FRAME_CYC = NBY * 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          halt_i = 1'b0;
    logic [NB-1:0] acc_i = '0;
    logic          tx_o, busy_o, done_o;

    bip_result_tx #(.NBITS_D(NB), .CLKS_PER_BIT(CPB)) dut (
        .i_clock (clk),
        .i_reset (rst_i),
        .i_Halt  (halt_i),
        .i_ACC   (acc_i),
        .o_Tx    (tx_o),
        .o_Busy  (busy_o),
        .o_Done  (done_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int cycle_n = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model: expected {tx,busy,done} per cycle as a queue of frames
    logic [2:0] mq[$];
    logic [2:0] exp_cur = 3'b100;
    logic       m_prev  = 1'b1;

    bit   log_en = 1'b0;
    int   log_idx = 0;
    logic tx_log[0:99];

    typedef struct {
        logic [NB-1:0] acc;
        logic [NB-1:0] acc_late;
        logic [NB-1:0] exp_word;
    } rec_t;

    rec_t recs[4];

    task automatic model_step(input logic rst, input logic halt, input logic [NB-1:0] acc);
        logic [9:0] fr;
        if (rst) begin
            mq.delete();
            m_prev  = 1'b1;
            exp_cur = 3'b100;
        end else begin
            if (halt && !m_prev && !exp_cur[1]) begin
                for (int k = 0; k < NBY; k++) begin
                    fr = {1'b1, acc[8*k +: 8], 1'b0};
                    for (int b = 0; b < 10; b++)
                        for (int c = 0; c < CPB; c++)
                            mq.push_back({fr[b], 1'b1, 1'b0});
                end
                mq.push_back(3'b101);
            end
            m_prev = halt;
            if (mq.size() > 0) exp_cur = mq.pop_front();
            else               exp_cur = 3'b100;
        end
    endtask

    task automatic tick(input logic rst, input logic halt, input logic [NB-1:0] acc);
        rst_i  = rst;
        halt_i = halt;
        acc_i  = acc;
        @(posedge clk);
        model_step(rst, halt, acc);
        @(negedge clk);
        cycle_n++;
        if (chk_en) begin
            vectors++;
            if ({tx_o, busy_o, done_o} !== exp_cur) begin
                fails++;
                $display("FAIL cycle %0d outputs{tx,busy,done}: got %b expected %b",
                         cycle_n, {tx_o, busy_o, done_o}, exp_cur);
            end
        end
        if (log_en && log_idx < 100) begin
            tx_log[log_idx] = tx_o;
            log_idx++;
        end
        if (done_o === 1'b1) done_cnt++;
    endtask

    task automatic run_record(input rec_t r);
        logic [NB-1:0] word;
        logic [2*NBY-1:0] framing;
        tick(1'b0, 1'b0, r.acc);
        log_idx = 0;
        log_en  = 1'b1;
        tick(1'b0, 1'b1, r.acc);
        for (int i = 1; i < FRAME_CYC; i++) tick(1'b0, 1'b1, r.acc_late);
        log_en = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, r.acc_late);
        for (int k = 0; k < NBY; k++) begin
            framing[2*k]   = tx_log[k*40 + 2];
            framing[2*k+1] = tx_log[k*40 + 38];
            for (int b = 0; b < 8; b++)
                word[8*k + b] = tx_log[k*40 + (1 + b)*CPB + 2];
        end
        vectors++;
        if (word !== r.exp_word) begin
            fails++;
            $display("FAIL decoded_word acc=%h: got %h expected %h", r.acc, word, r.exp_word);
        end
        vectors++;
        if (framing !== 4'b1010) begin
            fails++;
            $display("FAIL framing {stop,start}x2 acc=%h: got %b expected 1010", r.acc, framing);
        end
    endtask

    initial begin
        logic h;
        recs[0] = '{acc: 16'h1234, acc_late: 16'h1234, exp_word: 16'h1234};
        recs[1] = '{acc: 16'hA55A, acc_late: 16'h0000, exp_word: 16'hA55A};
        recs[2] = '{acc: 16'hFFFF, acc_late: 16'hFFFF, exp_word: 16'hFFFF};
        recs[3] = '{acc: 16'h8001, acc_late: 16'h7E7E, exp_word: 16'h8001};

        // Reset with i_Halt toggling, then one cycle after with i_Halt high
        tick(1'b1, 1'b0, '0);
        chk_en = 1'b1;
        tick(1'b1, 1'b1, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, '0);
        tick(1'b0, 1'b1, '0);

        for (int r = 0; r < 4; r++) begin
            done_cnt = 0;
            run_record(recs[r]);
            vectors++;
            if (done_cnt != 1) begin
                fails++;
                $display("FAIL done_pulses rec%0d: got %0d expected 1", r, done_cnt);
            end
            if (r == 0) begin
                done_cnt = 0;
                for (int i = 0; i < 200; i++) tick(1'b0, 1'b1, 16'h5555);
                vectors++;
                if (done_cnt != 0) begin
                    fails++;
                    $display("FAIL held_halt_done: got %0d expected 0", done_cnt);
                end
            end
        end

        // Reset during DATA bit 3 of byte 0, halt still high afterwards
        done_cnt = 0;
        tick(1'b0, 1'b0, 16'h00FF);
        tick(1'b0, 1'b1, 16'h00FF);
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 16'h00FF);
        tick(1'b1, 1'b1, 16'h00FF);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 16'h00FF);
        vectors++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL reset_abort_done: got %0d expected 0", done_cnt);
        end

        // Second rising edge while busy is lost
        done_cnt = 0;
        tick(1'b0, 1'b0, 16'h3C3C);
        tick(1'b0, 1'b1, 16'h3C3C);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 16'h3C3C);
        tick(1'b0, 1'b0, 16'h3C3C);
        for (int i = 0; i < 120; i++) tick(1'b0, 1'b1, 16'h3C3C);
        vectors++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL busy_edge_ignored_done: got %0d expected 1", done_cnt);
        end

        // Randomised traffic against the model
        h = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) h = ~h;
            tick(($urandom_range(0, 299) == 0), h, NB'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
